mmio_uart_tx: RTL
=================

// Module: mmio_uart_tx
// PURPOSE
// Memory-mapped UART transmitter on the CPU_Core data port, downstream of the core's d_w/daddr/ddata_w outputs.
// - Decodes a two-word window. Stores to that window are captured into a TX FIFO and serialised 8N1 on tx.
// - All other accesses pass through to the data RAM unchanged.
// - Gives programs such as fibonacci.hex a byte output channel that a bench can observe.
// PARAMETERS
// UART_BASE     10'h3F0  daddr of TXDATA; STATUS is at UART_BASE+1
// CLKS_PER_BIT  16       CLK cycles per serial bit, >=2
// FIFO_DEPTH    4        TX FIFO entries, power of 2, >=2
// PORTS
// CLK        in   1   clock, all state updates on rising edge
// RSTn       in   1   synchronous active-low reset
// daddr      in   10  data address from CPU_Core
// ddata_w    in   32  store data from CPU_Core
// d_w        in   1   store strobe from CPU_Core
// d_r        in   1   load strobe from CPU_Core
// ddata_r    out  32  load data to CPU_Core
// ram_rdata  in   32  read data from RAM
// ram_we     out  1   gated write enable to RAM
// ram_re     out  1   gated read enable to RAM
// tx         out  1   serial output, idle high
// BEHAVIOUR
// - sel = (daddr==UART_BASE)|(daddr==UART_BASE+1), combinational.
// - ram_we = d_w & ~sel; ram_re = d_r & ~sel.
// - ddata_r = (daddr==UART_BASE+1) ? STATUS : ram_rdata. TXDATA reads return 0. All combinational.
// - STATUS = {29'b0, overflow, full, busy}.
//   - busy = (state!=IDLE) | ~empty.
//   - full = (count==FIFO_DEPTH).
// - Reset (RSTn==0 at an edge): FIFO empty, overflow=0, state=IDLE, tx=1, baud counter=0, bit index=0.
//   - Reset applies mid-frame too: the frame is aborted and tx=1 on the next edge.
// - Push: at an edge with d_w & daddr==UART_BASE, ddata_w[7:0] is written to the FIFO if not full.
//   - If full, the byte is dropped and overflow is set to 1.
//   - Fullness is judged before any same-edge pop, so a push while full is dropped even if a pop occurs that edge.
// - Store to STATUS clears overflow. The store data is ignored.
// - FIFO: circular buffer with read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH.
//   - count ranges 0..FIFO_DEPTH.
//   - Simultaneous push (not full) and pop leaves count unchanged.
// - FSM, with tx and all counters registered:
//   - IDLE: tx=1. If FIFO not empty: pop into shreg, tx<=0, cnt<=0, go START.
//   - START: hold CLKS_PER_BIT cycles. On cnt==CLKS_PER_BIT-1: tx<=shreg[0], bit<=0, go DATA.
//   - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7: tx<=1, go STOP.
//   - STOP: hold CLKS_PER_BIT cycles, then go IDLE.
//     - Back-to-back: if the FIFO is not empty at the final STOP cycle, pop and go directly to START (no idle gap).
// - Latency: a byte pushed into an empty FIFO with state IDLE at edge N is popped at edge N+1; tx falls after edge N+1.
// - Frame length is exactly 10*CLKS_PER_BIT cycles.
// - No bit of RAM traffic is delayed: the pass-through paths are purely combinational.
// TESTING
// 1) CLKS_PER_BIT=4. Store 0x55 to 0x3F0 -> tx low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4; busy=0 after.
// 2) Six consecutive stores 0xA0..0xA5, one per cycle, from idle -> 0xA0 popped, 0xA1..0xA4 queued, 0xA5 dropped.
//    Then STATUS=3'b111, bytes A0..A4 sent back-to-back, total 50*CLKS_PER_BIT cycles.
// 3) With overflow=1, store any value to 0x3F1 -> next STATUS read has bit2=0.
// 4) Store 0x1234_5678 to 0x010, then load 0x010 -> ram_we=1 only on the store, ram_re=1 on the load.
//    ddata_r equals ram_rdata; tx stays 1; FIFO unchanged.
// 5) Load 0x3F1 while idle and empty -> ddata_r=0 and ram_re=0. Load 0x3F0 -> ddata_r=0.
// 6) RSTn low for one edge during DATA bit 3 -> tx=1, STATUS=0 the following cycle, and no further toggling.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
// Memory-mapped 8N1 UART transmitter that sits on the CPU data port.
// A two-word window is decoded: TXDATA at UART_BASE and STATUS at UART_BASE+1.
// Stores to TXDATA queue a byte in a small TX FIFO, which is then serialised on tx.
// Stores to STATUS clear the sticky overflow flag.
// Every other access passes straight through to the data RAM with no added delay.
//
// Ports
//   CLK        clock; all state changes on the rising edge
//   RSTn       synchronous active-low reset
//   daddr      data address from the core (10 bits)
//   ddata_w    store data from the core (only bits [7:0] are transmitted)
//   d_w, d_r   store / load strobes from the core
//   ddata_r    load data returned to the core (STATUS, 0 for TXDATA, otherwise RAM data)
//   ram_rdata  read data from the RAM
//   ram_we     RAM write enable, suppressed inside the UART window
//   ram_re     RAM read enable, suppressed inside the UART window
//   tx         serial output, idles high
//
// STATUS = {29'b0, overflow, full, busy}

module mmio_uart_tx #(
  parameter logic [9:0] UART_BASE    = 10'h3F0,
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [9:0]  daddr,
  input  logic [31:0] ddata_w,
  input  logic        d_w,
  input  logic        d_r,
  output logic [31:0] ddata_r,
  input  logic [31:0] ram_rdata,
  output logic        ram_we,
  output logic        ram_re,
  output logic        tx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [2:0]          bit_idx;
  logic [7:0]          shreg;
  logic [7:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                overflow;

  logic                addr_data;
  logic                addr_stat;
  logic                sel;
  logic                empty;
  logic                full;
  logic                busy;
  logic                push;
  logic                pop;
  logic                baud_last;
  logic [31:0]         status;

  // Upper store-data bits carry no meaning for a byte transmitter.
  logic                unused_ddata;
  assign unused_ddata = &{1'b0, ddata_w[31:8]};

  // Address decode and RAM pass-through (purely combinational).
  assign addr_data = (daddr == UART_BASE);
  assign addr_stat = (daddr == UART_BASE + 10'd1);
  assign sel       = addr_data | addr_stat;
  assign ram_we    = d_w & ~sel;
  assign ram_re    = d_r & ~sel;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign busy      = (state != IDLE) | ~empty;
  assign status    = {29'b0, overflow, full, busy};

  always_comb begin
    ddata_r = ram_rdata;
    if (addr_stat) begin
      ddata_r = status;
    end else if (addr_data) begin
      ddata_r = 32'h0;
    end
  end

  // Fullness is judged on the pre-edge count, so a push while full is dropped
  // even when the transmitter pops in the same cycle.
  assign push      = d_w & addr_data & ~full;
  assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

  // The transmitter takes a byte either from idle or on the final stop-bit
  // cycle, the latter giving back-to-back frames with no idle gap.
  assign pop = ~empty & ((state == IDLE) | ((state == STOP) & baud_last));

  // FIFO storage: no reset needed, the pointers define validity.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= ddata_w[7:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      // FIFO bookkeeping; pointers wrap naturally at a power-of-two depth.
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // Sticky overflow: set by a dropped byte, cleared by any STATUS store.
      if (d_w & addr_data & full) begin
        overflow <= 1'b1;
      end else if (d_w & addr_stat) begin
        overflow <= 1'b0;
      end

      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg    <= mem[rd_ptr];
            tx       <= 1'b0;
            baud_cnt <= '0;
            state    <= START;
          end
        end

        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            tx       <= shreg[0];
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              // Shift so the next data bit is always at shreg[1] -> shreg[0].
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (pop) begin
              shreg <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
